// File: rtl/cgra_x_heep_pkg.sv
// Shared CGRA <-> MCU types and constants.
// OBI bundles plus the payload stored by the request slice.
package cgra_x_heep_pkg;

   localparam int unsigned CGRA_OBI_MAX_OUTSTANDING = 2;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_payload_t;

   function automatic obi_payload_t obi_payload(input obi_req_t r);
      obi_payload_t p;
      p.we    = r.we;
      p.be    = r.be;
      p.addr  = r.addr;
      p.wdata = r.wdata;
      return p;
   endfunction

endpackage

// File: rtl/cgra_obi_master_slice_if.sv
// One OBI port: request bundle and response bundle.
// master drives the request, slave drives the response.
interface cgra_obi_master_slice_if;
   import cgra_x_heep_pkg::*;

   obi_req_t  req;
   obi_resp_t resp;

   modport master (output req, input resp);
   modport slave  (input req, output resp);

endinterface

// File: rtl/cgra_obi_req_fifo.sv
// Two-entry request buffer for the OBI slice.
// Head data reads as zero while the buffer is empty.
module cgra_obi_req_fifo
   import cgra_x_heep_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic         pop_i,
   input  obi_payload_t data_i,
   output obi_payload_t data_o,
   output logic [1:0]   count_o,
   output logic         empty_o,
   output logic         full_o
);

   obi_payload_t mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;
   logic         push_en;
   logic         pop_en;

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign count_o = count_q;
   assign push_en = push_i && !full_o;
   assign pop_en  = pop_i && !empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_en) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_en) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + {1'b0, push_en} - {1'b0, pop_en};
      end
   end

endmodule

// File: rtl/cgra_obi_master_slice.sv
// Register slice between a CGRA OBI master and the crossbar.
// Buffers requests, caps in-flight count, registers responses.
module cgra_obi_master_slice
   import cgra_x_heep_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = CGRA_OBI_MAX_OUTSTANDING,
   parameter int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   cgra_obi_master_slice_if.slave    slave_port,
   cgra_obi_master_slice_if.master   master_port,
   output logic [CNT_W-1:0]          outstanding_o,
   output logic                      idle_o,
   output logic                      err_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   obi_payload_t     head;
   logic [1:0]       fifo_count;
   logic             fifo_empty;
   logic             fifo_full;
   logic             up_gnt;
   logic             push;
   logic             issue;
   logic             hs;
   logic             rsp;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   logic             resp_valid_q;
   logic [31:0]      rdata_q;
   obi_req_t         m_req;
   obi_resp_t        s_resp;

   // Grant depends only on buffer occupancy, never on the crossbar.
   assign up_gnt = !fifo_full;
   assign push   = slave_port.req.req && up_gnt;
   assign issue  = !fifo_empty && (cnt_q < CNT_MAX);
   assign hs     = issue && master_port.resp.gnt;
   assign rsp    = master_port.resp.rvalid;

   cgra_obi_req_fifo u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .pop_i   (hs),
      .data_i  (obi_payload(slave_port.req)),
      .data_o  (head),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Downstream request: FIFO head while issue is allowed, else zero.
   always_comb begin
      m_req = '0;
      if (issue) begin
         m_req.req   = 1'b1;
         m_req.we    = head.we;
         m_req.be    = head.be;
         m_req.addr  = head.addr;
         m_req.wdata = head.wdata;
      end
   end

   // Upstream response comes entirely from registered state.
   always_comb begin
      s_resp        = '0;
      s_resp.gnt    = up_gnt;
      s_resp.rvalid = resp_valid_q;
      s_resp.rdata  = rdata_q;
   end

   assign master_port.req  = m_req;
   assign slave_port.resp  = s_resp;

   // In-flight counter and sticky error on unexpected rvalid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         unique case ({hs, rsp})
            2'b10: cnt_q <= cnt_q + CNT_W'(1);
            2'b01: if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (rsp && (cnt_q == '0)) begin
            err_q <= 1'b1;
         end
      end
   end

   // Response register; data is zeroed when no response is valid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_valid_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         resp_valid_q <= rsp;
         rdata_q      <= rsp ? master_port.resp.rdata : 32'h0;
      end
   end

   assign outstanding_o = cnt_q;
   assign err_o         = err_q;
   assign idle_o        = (fifo_count == 2'd0) && (cnt_q == '0) && !resp_valid_q;

endmodule
